// File: rtl/display_scheduler_if.sv
// Display scheduler bus: mode switches, BCD digit sources, alarm/button events in;
// multiplexed 7-segment drive and status out.
interface display_scheduler_if;
    logic        clock_set;
    logic        alarm_set;
    logic        stop_watch;
    logic        alarm_on;
    logic [1:0]  loc;
    logic [15:0] clk_digits;
    logic [15:0] alarm_digits;
    logic [15:0] sw_digits;
    logic        alarm_match;
    logic        tick_1s;
    logic        ack;
    logic        ack_sw;
    logic [3:0]  anode;
    logic [6:0]  seg;
    logic [1:0]  src;
    logic        ringing;

    modport master (
        output clock_set, alarm_set, stop_watch, alarm_on, loc,
               clk_digits, alarm_digits, sw_digits, alarm_match, tick_1s, ack,
        input  ack_sw, anode, seg, src, ringing
    );

    modport slave (
        input  clock_set, alarm_set, stop_watch, alarm_on, loc,
               clk_digits, alarm_digits, sw_digits, alarm_match, tick_1s, ack,
        output ack_sw, anode, seg, src, ringing
    );
endinterface

// File: rtl/display_scheduler.sv
// Arbitrates the shared 4-digit 7-segment display between clock, time-set, alarm-set
// and stopwatch views; scans the anodes, blinks the edited digit and runs the alarm ring.
module display_scheduler #(
    parameter int unsigned SCAN_DIV  = 100000,
    parameter int unsigned BLINK_DIV = 50000000,
    parameter int unsigned RING_SEC  = 30
) (
    input  logic               MCLK,
    input  logic               RESET,
    display_scheduler_if.slave dsp
);

    localparam int unsigned SCAN_W  = (SCAN_DIV  > 2) ? $clog2(SCAN_DIV)  : 1;
    localparam int unsigned BLINK_W = (BLINK_DIV > 2) ? $clog2(BLINK_DIV) : 1;
    localparam int unsigned RING_W  = (RING_SEC  > 2) ? $clog2(RING_SEC)  : 1;

    localparam logic [1:0] SRC_CLOCK = 2'd0;
    localparam logic [1:0] SRC_SET   = 2'd1;
    localparam logic [1:0] SRC_ALARM = 2'd2;
    localparam logic [1:0] SRC_SW    = 2'd3;

    typedef enum logic {IDLE = 1'b0, RING = 1'b1} ring_state_e;

    ring_state_e        state_q, state_d;
    logic [SCAN_W-1:0]  scan_cnt_q, scan_cnt_d;
    logic [1:0]         idx_q, idx_d;
    logic [1:0]         src_q, src_d;
    logic [BLINK_W-1:0] blink_cnt_q, blink_cnt_d;
    logic               blink_phase_q, blink_phase_d;
    logic               match_hist_q, match_hist_d;
    logic [RING_W-1:0]  ring_cnt_q, ring_cnt_d;
    logic [3:0]         anode_q, anode_d;
    logic [6:0]         seg_q, seg_d;

    logic        scan_wrap, frame_end, blink_wrap, edit_view, ring_enter, ring_timeout;
    logic [1:0]  req_src;
    logic [15:0] disp_vec;
    logic [3:0]  nibble;

    function automatic logic [6:0] seg_decode(input logic [3:0] bcd);
        logic [6:0] pat;
        case (bcd)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            default: pat = 7'h7F;
        endcase
        return pat;
    endfunction

    assign scan_wrap    = (scan_cnt_q == SCAN_W'(SCAN_DIV - 1));
    assign frame_end    = scan_wrap && (idx_q == 2'd3);
    assign blink_wrap   = (blink_cnt_q == BLINK_W'(BLINK_DIV - 1));
    assign edit_view    = (src_q == SRC_SET) || (src_q == SRC_ALARM);
    assign ring_timeout = dsp.tick_1s && (ring_cnt_q == RING_W'(RING_SEC - 1));
    assign match_hist_d = dsp.alarm_match;

    // Fixed-priority source request
    always_comb begin
        if (dsp.clock_set)       req_src = SRC_SET;
        else if (dsp.alarm_set)  req_src = SRC_ALARM;
        else if (dsp.stop_watch) req_src = SRC_SW;
        else                     req_src = SRC_CLOCK;
    end

    // Digit scan; the displayed source only changes between whole frames
    always_comb begin
        scan_cnt_d = scan_cnt_q + SCAN_W'(1);
        idx_d      = idx_q;
        if (scan_wrap) begin
            scan_cnt_d = '0;
            idx_d      = idx_q + 2'd1;
        end
        src_d = frame_end ? req_src : src_q;
    end

    // Ring FSM
    always_comb begin
        state_d    = state_q;
        ring_cnt_d = ring_cnt_q;
        ring_enter = 1'b0;
        case (state_q)
            IDLE: begin
                if (dsp.alarm_match && !match_hist_q && dsp.alarm_on &&
                    ((src_q == SRC_CLOCK) || (src_q == SRC_SW))) begin
                    state_d    = RING;
                    ring_cnt_d = '0;
                    ring_enter = 1'b1;
                end
            end
            RING: begin
                if (dsp.ack || !dsp.alarm_on || ring_timeout) begin
                    state_d = IDLE;
                end else if (dsp.tick_1s) begin
                    ring_cnt_d = ring_cnt_q + RING_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Blink restarts in the visible phase whenever the view changes
    always_comb begin
        blink_cnt_d   = blink_cnt_q + BLINK_W'(1);
        blink_phase_d = blink_phase_q;
        if ((src_d != src_q) || ring_enter) begin
            blink_cnt_d   = '0;
            blink_phase_d = 1'b0;
        end else if (blink_wrap) begin
            blink_cnt_d   = '0;
            blink_phase_d = !blink_phase_q;
        end
    end

    // Digit data and blanking; ringing forces the running time and flashes all digits
    always_comb begin
        disp_vec = dsp.clk_digits;
        if (state_q == IDLE) begin
            case (src_q)
                SRC_ALARM: disp_vec = dsp.alarm_digits;
                SRC_SW:    disp_vec = dsp.sw_digits;
                default:   disp_vec = dsp.clk_digits;
            endcase
        end
        nibble  = disp_vec[{idx_q, 2'b00} +: 4];
        seg_d   = seg_decode(nibble);
        anode_d = ~(4'b0001 << idx_q);
        if (blink_phase_q &&
            ((state_q == RING) || (edit_view && (idx_q == dsp.loc)))) begin
            anode_d = 4'hF;
        end
    end

    always_ff @(posedge MCLK or posedge RESET) begin
        if (RESET) begin
            state_q       <= IDLE;
            scan_cnt_q    <= '0;
            idx_q         <= '0;
            src_q         <= SRC_CLOCK;
            blink_cnt_q   <= '0;
            blink_phase_q <= 1'b0;
            match_hist_q  <= 1'b0;
            ring_cnt_q    <= '0;
            anode_q       <= 4'hF;
            seg_q         <= 7'h7F;
        end else begin
            state_q       <= state_d;
            scan_cnt_q    <= scan_cnt_d;
            idx_q         <= idx_d;
            src_q         <= src_d;
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
            match_hist_q  <= match_hist_d;
            ring_cnt_q    <= ring_cnt_d;
            anode_q       <= anode_d;
            seg_q         <= seg_d;
        end
    end

    assign dsp.anode   = anode_q;
    assign dsp.seg     = seg_q;
    assign dsp.src     = src_q;
    assign dsp.ringing = (state_q == RING);
    assign dsp.ack_sw  = dsp.ack && (state_q == IDLE);

endmodule

// File: tb/tb_display_scheduler.sv
// Bench for display_scheduler: directed scenarios plus randomized traffic against a
// cycle-count based reference model of the display schedule and alarm ring.
module tb_display_scheduler;

    localparam int unsigned S = 4;
    localparam int unsigned B = 16;
    localparam int unsigned R = 3;

    logic MCLK  = 1'b0;
    logic RESET = 1'b1;
    int   checks = 0;
    int   errors = 0;

    display_scheduler_if ifc();

    display_scheduler #(.SCAN_DIV(S), .BLINK_DIV(B), .RING_SEC(R)) dut (
        .MCLK  (MCLK),
        .RESET (RESET),
        .dsp   (ifc)
    );

    always #5 MCLK = ~MCLK;

    // Reference model state: time since reset and time of last blink restart
    int unsigned m_t, m_base, m_ticks;
    logic [1:0]  m_src;
    logic        m_ring, m_hist;
    logic [3:0]  m_anode;
    logic [6:0]  m_seg;

    function automatic logic [6:0] pat(input logic [3:0] d);
        case (d)
            4'd0: return 7'h40;  4'd1: return 7'h79;  4'd2: return 7'h24;
            4'd3: return 7'h30;  4'd4: return 7'h19;  4'd5: return 7'h12;
            4'd6: return 7'h02;  4'd7: return 7'h78;  4'd8: return 7'h00;
            4'd9: return 7'h10;  default: return 7'h7F;
        endcase
    endfunction

    task automatic model_reset();
        m_t = 0; m_base = 0; m_ticks = 0; m_src = 2'd0; m_ring = 1'b0; m_hist = 1'b0;
        m_anode = 4'hF; m_seg = 7'h7F;
    endtask

    task automatic model_update();
        int unsigned idx;
        logic phase, frame_end, enter, leave;
        logic [1:0] req, nsrc;
        logic [15:0] vec;
        idx       = (m_t / S) % 4;
        frame_end = ((m_t % S) == S - 1) && (idx == 3);
        phase     = (((m_t - m_base) / B) % 2) == 1;
        if (m_ring || m_src == 2'd0 || m_src == 2'd1) vec = ifc.clk_digits;
        else if (m_src == 2'd2)                       vec = ifc.alarm_digits;
        else                                          vec = ifc.sw_digits;
        m_seg = pat(4'(vec >> (4 * idx)));
        if (phase && (m_ring || ((m_src == 2'd1 || m_src == 2'd2) && idx == 32'(ifc.loc))))
            m_anode = 4'hF;
        else
            m_anode = ~(4'b0001 << idx);
        req = ifc.clock_set ? 2'd1 : ifc.alarm_set ? 2'd2 : ifc.stop_watch ? 2'd3 : 2'd0;
        enter = 1'b0; leave = 1'b0;
        if (!m_ring) enter = ifc.alarm_match && !m_hist && ifc.alarm_on && (m_src == 2'd0 || m_src == 2'd3);
        else         leave = ifc.ack || !ifc.alarm_on || (ifc.tick_1s && m_ticks + 1 >= R);
        if (enter) begin m_ring = 1'b1; m_ticks = 0; end
        else if (leave) m_ring = 1'b0;
        else if (m_ring && ifc.tick_1s) m_ticks++;
        nsrc = frame_end ? req : m_src;
        if (nsrc != m_src || enter) m_base = m_t + 1;
        m_src  = nsrc;
        m_hist = ifc.alarm_match;
        m_t++;
    endtask

    task automatic step();
        @(posedge MCLK);
        if (!RESET) model_update();
        #1;
    endtask

    task automatic test_reset();
        ifc.clock_set = 0; ifc.alarm_set = 0; ifc.stop_watch = 0; ifc.alarm_on = 0;
        ifc.loc = 2'd0; ifc.clk_digits = 16'h1234; ifc.alarm_digits = 16'h0630;
        ifc.sw_digits = 16'h0000; ifc.alarm_match = 0; ifc.tick_1s = 0; ifc.ack = 0;
        RESET = 1'b1;
        model_reset();
        step(); step();
        checks++; if (ifc.anode !== 4'hF) begin errors++; $display("FAIL reset_anode got %b want 1111", ifc.anode); end
        checks++; if (ifc.seg !== 7'h7F) begin errors++; $display("FAIL reset_seg got %h want 7f", ifc.seg); end
        checks++; if (ifc.src !== 2'd0) begin errors++; $display("FAIL reset_src got %0d want 0", ifc.src); end
        checks++; if (ifc.ringing !== 1'b0) begin errors++; $display("FAIL reset_ringing got %b want 0", ifc.ringing); end
        RESET = 1'b0;
    endtask

    task automatic test_scan();
        logic [3:0] an_tbl [4];
        logic [6:0] sg_tbl [4];
        an_tbl = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        sg_tbl = '{7'h19, 7'h30, 7'h24, 7'h79};
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (ifc.anode !== an_tbl[k / 4] || ifc.seg !== sg_tbl[k / 4] || ifc.src !== 2'd0) begin
                errors++;
                $display("FAIL scan k=%0d got an=%b seg=%h src=%0d want an=%b seg=%h src=0",
                         k, ifc.anode, ifc.seg, ifc.src, an_tbl[k / 4], sg_tbl[k / 4]);
            end
        end
    endtask

    task automatic test_mode_switch();
        int blanks;
        for (int k = 0; k < 6; k++) step();
        ifc.clock_set = 1; ifc.stop_watch = 1; ifc.loc = 2'd2;
        for (int k = 1; k <= 12; k++) begin
            step();
            checks++;
            if (ifc.src !== ((k >= 10) ? 2'd1 : 2'd0)) begin
                errors++; $display("FAIL mode_switch_latency k=%0d got src=%0d want %0d", k, ifc.src, (k >= 10) ? 1 : 0);
            end
        end
        blanks = 0;
        for (int k = 0; k < 14; k++) begin
            step();
            if (ifc.anode === 4'hF) blanks++;
            checks++;
            if ({ifc.anode, ifc.seg, ifc.src, ifc.ringing} !== {m_anode, m_seg, m_src, m_ring}) begin
                errors++;
                $display("FAIL mode_switch_model t=%0d got an=%b seg=%h src=%0d ring=%b want an=%b seg=%h src=%0d ring=%b",
                         m_t, ifc.anode, ifc.seg, ifc.src, ifc.ringing, m_anode, m_seg, m_src, m_ring);
            end
        end
        checks++; if (blanks != 0) begin errors++; $display("FAIL first_window_visible got %0d blanks want 0", blanks); end
        blanks = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            if (ifc.anode === 4'hF) blanks++;
        end
        checks++; if (blanks != 4) begin errors++; $display("FAIL blink_edit_digit got %0d blanks want 4", blanks); end
    endtask

    task automatic test_invalid_bcd();
        logic [6:0] sg_tbl [4];
        int n;
        sg_tbl = '{7'h10, 7'h40, 7'h7F, 7'h12};
        ifc.clock_set = 0; ifc.sw_digits = 16'h5A09;
        n = 0;
        while (ifc.src !== 2'd3 && n < 40) begin step(); n++; end
        checks++; if (ifc.src !== 2'd3) begin errors++; $display("FAIL sw_src_timeout got src=%0d want 3", ifc.src); end
        for (int k = 0; k < 16; k++) begin
            step();
            checks++;
            if (ifc.anode !== ~(4'b0001 << (k / 4)) || ifc.seg !== sg_tbl[k / 4]) begin
                errors++;
                $display("FAIL sw_digits k=%0d got an=%b seg=%h want seg=%h", k, ifc.anode, ifc.seg, sg_tbl[k / 4]);
            end
        end
    endtask

    task automatic test_ring_ack();
        ifc.ack = 1; #1;
        checks++; if (ifc.ack_sw !== 1'b1) begin errors++; $display("FAIL ack_sw_idle got %b want 1", ifc.ack_sw); end
        ifc.ack = 0;
        ifc.alarm_on = 1; ifc.alarm_match = 1; ifc.clk_digits = 16'h0731;
        step();
        checks++; if (ifc.ringing !== 1'b1) begin errors++; $display("FAIL ring_start got %b want 1", ifc.ringing); end
        for (int k = 0; k < 24; k++) begin
            step();
            checks++;
            if ({ifc.anode, ifc.seg, ifc.src, ifc.ringing} !== {m_anode, m_seg, m_src, m_ring}) begin
                errors++;
                $display("FAIL ring_display_model t=%0d got an=%b seg=%h src=%0d ring=%b want an=%b seg=%h src=%0d ring=%b",
                         m_t, ifc.anode, ifc.seg, ifc.src, ifc.ringing, m_anode, m_seg, m_src, m_ring);
            end
        end
        ifc.ack = 1; #1;
        checks++; if (ifc.ack_sw !== 1'b0) begin errors++; $display("FAIL ack_sw_gated got %b want 0", ifc.ack_sw); end
        step();
        ifc.ack = 0;
        checks++; if (ifc.ringing !== 1'b0) begin errors++; $display("FAIL ring_ack_stop got %b want 0", ifc.ringing); end
    endtask

    task automatic test_ring_timeout();
        for (int k = 0; k < 8; k++) step();
        checks++; if (ifc.ringing !== 1'b0) begin errors++; $display("FAIL no_retrigger_after_ack got %b want 0", ifc.ringing); end
        ifc.alarm_match = 0; step();
        ifc.alarm_match = 1; step();
        checks++; if (ifc.ringing !== 1'b1) begin errors++; $display("FAIL ring_restart got %b want 1", ifc.ringing); end
        for (int n = 1; n <= 3; n++) begin
            ifc.tick_1s = 1; step(); ifc.tick_1s = 0;
            checks++;
            if (ifc.ringing !== (n < 3)) begin
                errors++; $display("FAIL ring_timeout tick=%0d got %b want %b", n, ifc.ringing, n < 3);
            end
            step(); step();
        end
        for (int k = 0; k < 10; k++) begin
            step();
            checks++;
            if (ifc.ringing !== 1'b0 || ifc.ringing !== m_ring) begin
                errors++; $display("FAIL no_retrigger_held k=%0d got %b want 0", k, ifc.ringing);
            end
        end
        ifc.alarm_match = 0; step();
        ifc.alarm_match = 1; step();
        checks++; if (ifc.ringing !== 1'b1) begin errors++; $display("FAIL ring_new_edge got %b want 1", ifc.ringing); end
    endtask

    task automatic test_reset_mid_ring();
        RESET = 1'b1;
        model_reset();
        #1;
        checks++;
        if (ifc.anode !== 4'hF || ifc.seg !== 7'h7F || ifc.ringing !== 1'b0 || ifc.src !== 2'd0) begin
            errors++;
            $display("FAIL reset_mid_ring got an=%b seg=%h ring=%b src=%0d want an=1111 seg=7f ring=0 src=0",
                     ifc.anode, ifc.seg, ifc.ringing, ifc.src);
        end
        ifc.alarm_match = 0; ifc.stop_watch = 0;
        step(); step();
        RESET = 1'b0;
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(199) == 0) ifc.clock_set  = !ifc.clock_set;
            if ($urandom_range(199) == 0) ifc.alarm_set  = !ifc.alarm_set;
            if ($urandom_range(149) == 0) ifc.stop_watch = !ifc.stop_watch;
            if ($urandom_range(299) == 0) ifc.alarm_on   = !ifc.alarm_on;
            if ($urandom_range(39) == 0)  ifc.alarm_match = !ifc.alarm_match;
            if ($urandom_range(49) == 0)  ifc.loc = 2'($urandom_range(3));
            if ($urandom_range(99) == 0) begin
                ifc.clk_digits = 16'($urandom); ifc.alarm_digits = 16'($urandom); ifc.sw_digits = 16'($urandom);
            end
            ifc.tick_1s = ($urandom_range(19) == 0);
            ifc.ack     = ($urandom_range(29) == 0);
            #1;
            checks++;
            if (ifc.ack_sw !== (ifc.ack && !m_ring)) begin
                errors++; $display("FAIL rand_ack_sw t=%0d got %b want %b", m_t, ifc.ack_sw, ifc.ack && !m_ring);
            end
            step();
            checks++;
            if ({ifc.anode, ifc.seg, ifc.src, ifc.ringing} !== {m_anode, m_seg, m_src, m_ring}) begin
                errors++;
                $display("FAIL rand_model t=%0d got an=%b seg=%h src=%0d ring=%b want an=%b seg=%h src=%0d ring=%b",
                         m_t, ifc.anode, ifc.seg, ifc.src, ifc.ringing, m_anode, m_seg, m_src, m_ring);
            end
        end
        ifc.tick_1s = 0; ifc.ack = 0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_mode_switch();
        test_invalid_bcd();
        test_ring_ack();
        test_ring_timeout();
        test_reset_mid_ring();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/display_scheduler.md
Name: display_scheduler

Overview:
- Owns the shared 4-digit 7-segment display and arbitrates it between four sources: running clock, time-set, alarm-set and stopwatch.
- Time-multiplexes the anodes and blinks the digit being edited.
- Runs the alarm-ring FSM, which overrides the display and gates the center button away from the stopwatch while the alarm rings.
- Sits in the top level, after the time counter, time-set and stopwatch outputs.

Parameters:
SCAN_DIV, 100000, MCLK cycles per digit slot (1 kHz digit rate at 100 MHz)
BLINK_DIV, 50000000, MCLK cycles per blink half-period (0.5 s)
RING_SEC, 30, seconds the alarm rings before auto-stop

Ports:
MCLK  in  1  board clock
RESET  in  1  asynchronous active-high reset
clock_set  in  1  time-set mode switch
alarm_set  in  1  alarm-set mode switch
stop_watch  in  1  stopwatch mode switch
alarm_on  in  1  alarm arm switch
loc  in  2  digit under edit: 0=sec01, 1=sec10, 2=min01, 3=min10
clk_digits  in  16  {min10,min01,sec10,sec01} BCD of current/edited time
alarm_digits  in  16  alarm time BCD, same packing
sw_digits  in  16  {SEC_10,SEC_01,MSEC_10,MSEC_01} stopwatch BCD
alarm_match  in  1  level: current time equals alarm time
tick_1s  in  1  one-MCLK pulse per second
ack  in  1  filtered center-button pulse (one MCLK)
ack_sw  out  1  ack forwarded to stopwatch (ack & ~ringing)
anode  out  4  active-low digit enables; bit i = digit i
seg  out  7  active-low segments {g,f,e,d,c,b,a}
src  out  2  displayed source: 0 clock, 1 time-set, 2 alarm-set, 3 stopwatch
ringing  out  1  alarm ring indicator

Behaviour:
- Reset (async, RESET=1): anode=4'hF, seg=7'h7F, src=0, ringing=0, scan/blink counters=0, digit index=0, blink_phase=0, alarm_match history=0.
- Arbitration, fixed priority: clock_set > alarm_set > stop_watch > clock. The result is req_src.
- src loads req_src only at a frame boundary: scan counter wraps while digit index=3. No torn frames; worst-case latency to a new source is 4*SCAN_DIV cycles.
- Scan: counter counts 0..SCAN_DIV-1. On wrap, digit index increments mod 4.
- anode and seg are registered: one-cycle latency from index/data to pins.
- Digit data is nibble [4*idx+3:4*idx] of the selected source vector. Src 0 and 1 use clk_digits, src 2 uses alarm_digits, src 3 uses sw_digits.
- Decode: 0-9 uses standard active-low patterns (0 -> 7'b1000000, 1 -> 7'b1111001, 8 -> 7'b0000000). Values 10-15 drive seg=7'h7F.
- Blink: counter counts 0..BLINK_DIV-1 and toggles blink_phase on wrap. The counter and blink_phase clear to 0 on any src change, so the edited digit is visible immediately.
- In src 1 or 2 with blink_phase=1, the digit with idx==loc is blanked (anode bit held 1). All other digits display normally.
- Ring FSM, IDLE/RING:
  - IDLE->RING on rising edge of alarm_match (registered history) while alarm_on=1 and src is 0 or 3. No trigger during clock_set or alarm_set.
  - On entering RING: ring second counter=0, blink counter and blink_phase cleared.
  - RING->IDLE on the first of: ack=1; alarm_on=0; ring counter reaching RING_SEC (counter increments on tick_1s).
  - Exit priority when simultaneous: all exits are equivalent; the FSM goes to IDLE in that cycle.
  - alarm_match staying high after ack does not re-trigger; a new rising edge is required.
- In RING: display forced to clk_digits regardless of src. All four digits blank when blink_phase=1. ringing=1. ack_sw=0.
- src keeps tracking the arbiter during RING; the display returns to it on exit.
- ack_sw = ack when IDLE, combinational pass-through.
- RESET mid-ring returns to IDLE with all outputs at reset values.
- Mode switch mid-frame: the current frame completes with the old source.

Test Plan:
(Test parameters: SCAN_DIV=4, BLINK_DIV=16, RING_SEC=3.)
- Reset then release, clk_digits=16'h1234, all switches 0 -> anode sequence 1110,1101,1011,0111, each held 4 cycles; seg shows 4,3,2,1; src=0.
- Assert clock_set and stop_watch together mid-frame -> src=1 only after digit 3 slot ends. With loc=2, digit 2 is blanked during every other 16-cycle blink window; the first window after the switch is visible.
- Stopwatch mode, sw_digits=16'h5A09 -> digit 2 seg=7'h7F (invalid BCD); the other digits show 5,0,9.
- alarm_on=1, alarm_match rises -> ringing=1 next cycle; display shows clk_digits and flashes whole. ack pulse -> ringing=0 and ack_sw stays 0 that cycle.
- Ring with no ack: three tick_1s pulses -> ringing=0 after the third. alarm_match held high -> no re-ring. Lower then raise alarm_match -> ring again.
- Assert RESET during RING -> anode=4'hF, seg=7'h7F, ringing=0 immediately (async).
